// File: rtl/dcache_banked_strided.sv
// Banked tile data cache: SZ strided rows spread over 2^LOGCNT single-port banks.
// Rows that collide on a bank are serialized over extra issue rounds.
module dcache_banked_strided #(
    parameter  int SZ        = 4,
    parameter  int LOGCNT    = 5,
    parameter  int BITS      = 18,
    parameter  int DEPTH_LOG = 10,
    localparam int AW        = DEPTH_LOG + LOGCNT,
    localparam int LINE      = BITS * SZ,
    localparam int CNT       = 1 << LOGCNT,
    localparam int DEPTH     = 1 << DEPTH_LOG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [AW-1:0]      req_addr,
    input  logic [AW-1:0]      req_stride_y,
    input  logic [SZ*LINE-1:0] req_dat_w,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_we,
    output logic [SZ*LINE-1:0] rsp_dat,
    output logic [31:0]        conflict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e             state_q;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [AW-1:0]      stride_q;
    logic [SZ*LINE-1:0] wdat_q;
    logic [AW-1:0]      row_q [SZ];
    logic [SZ-1:0]      pend_q;
    logic [SZ-1:0]      rd_pend_q;
    logic [LOGCNT-1:0]  rd_bank_q [SZ];
    logic               first_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               rsp_we_q;
    logic [SZ*LINE-1:0] rsp_dat_q;
    logic [31:0]        cnt_q;

    logic [SZ-1:0]        sel;
    logic [CNT-1:0]       ben;
    logic [DEPTH_LOG-1:0] bidx [CNT];
    logic [LINE-1:0]      bwd  [CNT];
    logic [LINE-1:0]      brd  [CNT];

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_we       = rsp_we_q;
    assign rsp_dat      = rsp_dat_q;
    assign conflict_cnt = cnt_q;

    // A pending row issues only if no lower-index pending row shares its bank.
    always_comb begin
        for (int y = 0; y < SZ; y++) begin
            sel[y] = pend_q[y];
            for (int z = 0; z < y; z++) begin
                if (pend_q[z] &&
                    row_q[z][LOGCNT-1:0] == row_q[y][LOGCNT-1:0]) begin
                    sel[y] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        ben = '0;
        for (int b = 0; b < CNT; b++) begin
            bidx[b] = '0;
            bwd[b]  = '0;
        end
        for (int b = 0; b < CNT; b++) begin
            for (int y = 0; y < SZ; y++) begin
                if (sel[y] && row_q[y][LOGCNT-1:0] == LOGCNT'(b)) begin
                    ben[b]  = 1'b1;
                    bidx[b] = row_q[y][AW-1:LOGCNT];
                    bwd[b]  = wdat_q[LINE*y +: LINE];
                end
            end
        end
    end

    for (genvar b = 0; b < CNT; b++) begin : g_bank
        logic [LINE-1:0] mem [DEPTH];
        logic [LINE-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (ben[b]) begin
                if (we_q) begin
                    mem[bidx[b]] <= bwd[b];
                end else begin
                    rd_q <= mem[bidx[b]];
                end
            end
        end

        assign brd[b] = rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            stride_q    <= '0;
            wdat_q      <= '0;
            pend_q      <= '0;
            rd_pend_q   <= '0;
            first_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_dat_q   <= '0;
            cnt_q       <= '0;
            for (int y = 0; y < SZ; y++) begin
                row_q[y]     <= '0;
                rd_bank_q[y] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        stride_q    <= req_stride_y;
                        wdat_q      <= req_dat_w;
                        req_ready_q <= 1'b0;
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    for (int y = 0; y < SZ; y++) begin
                        row_q[y] <= addr_q + stride_q * AW'(y);
                    end
                    pend_q    <= '1;
                    first_q   <= 1'b1;
                    rsp_dat_q <= '0;
                    rsp_we_q  <= we_q;
                    state_q   <= S_ISSUE;
                end
                S_ISSUE: begin
                    pend_q    <= pend_q & ~sel;
                    first_q   <= 1'b0;
                    rd_pend_q <= sel & {SZ{~we_q}};
                    for (int y = 0; y < SZ; y++) begin
                        rd_bank_q[y] <= row_q[y][LOGCNT-1:0];
                        if (rd_pend_q[y]) begin
                            rsp_dat_q[LINE*y +: LINE] <= brd[rd_bank_q[y]];
                        end
                    end
                    // Every round after the first is an extra conflict round.
                    if (pend_q != '0 && !first_q && cnt_q != '1) begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                    if (pend_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
